// File: rtl/mux_rr_scheduler.sv
// rtl/mux_rr_scheduler.sv - round-robin burst scheduler in front of an N-way data mux
//
// Purpose: grants one of N requesters ownership of a W-bit output mux for
// up to BURST beats, then returns to IDLE for one cycle and re-arbitrates
// starting just after the previous owner.
//
// Ports:
//   clk        - clock, all state changes on the rising edge
//   rst        - synchronous active-high reset
//   req        - [N-1:0] per-requester "beat available"
//   in_data    - [N*W-1:0] requester i data on bits [i*W +: W]
//   out_ready  - downstream accepts the presented beat
//   out_valid  - a beat is presented on out_data
//   out_data   - [W-1:0] granted requester's data, 0 when not valid
//   ack        - [N-1:0] one-hot pulse to the requester whose beat transferred
//   grant      - [N-1:0] registered one-hot owner, 0 when idle
//   select     - [m-1:0] registered mux select, holds last owner when idle

module mux_rr_scheduler #(
  parameter int N     = 4,
  parameter int m     = 2,
  parameter int W     = 4,
  parameter int BURST = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic [N*W-1:0]   in_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  output logic [N-1:0]     ack,
  output logic [N-1:0]     grant,
  output logic [m-1:0]     select
);

  localparam int            CW        = $clog2(BURST + 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST - 1);
  localparam logic [m-1:0]  LAST_IDX  = m'(N - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state;
  logic [m-1:0]    ptr;
  logic [CW-1:0]   beat;

  logic            found;
  logic [m-1:0]    pick;
  logic [m:0]      cand;
  logic            xfer;
  logic [m-1:0]    next_ptr;

  // Search from ptr upward, wrapping at N (not at 2**m) so non-power-of-two
  // N never produces an out-of-range index.
  always_comb begin
    found = 1'b0;
    pick  = ptr;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr} + (m+1)'(k);
      if (cand >= (m+1)'(N)) begin
        cand = cand - (m+1)'(N);
      end
      if (!found && req[cand[m-1:0]]) begin
        found = 1'b1;
        pick  = cand[m-1:0];
      end
    end
  end

  always_comb begin
    out_valid = (state == GRANT) && req[select];
    out_data  = out_valid ? in_data[select*W +: W] : '0;
    xfer      = out_valid && out_ready;
    // grant is the one-hot of select while in GRANT and 0 in IDLE
    ack       = xfer ? grant : '0;
    next_ptr  = (select == LAST_IDX) ? '0 : select + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= '0;
      select <= '0;
      grant  <= '0;
      beat   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            select <= pick;
            grant  <= {{(N-1){1'b0}}, 1'b1} << pick;
            beat   <= '0;
            state  <= GRANT;
          end
        end
        GRANT: begin
          if (!req[select]) begin
            // owner dropped its request: release without a transfer
            state <= IDLE;
            grant <= '0;
            ptr   <= next_ptr;
          end else if (out_ready) begin
            if (beat == LAST_BEAT) begin
              state <= IDLE;
              grant <= '0;
              ptr   <= next_ptr;
            end else begin
              beat <= beat + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// tb/tb_mux_rr_scheduler.sv - self-checking bench for mux_rr_scheduler (N=4 and N=3 instances)

module tb_mux_rr_scheduler;

  localparam int BURST = 2;

  logic        clk;
  logic        rst;

  logic [3:0]  req4;
  logic [15:0] data4;
  logic        ready4;
  logic        valid4;
  logic [3:0]  odata4;
  logic [3:0]  ack4;
  logic [3:0]  grant4;
  logic [1:0]  sel4;

  logic [2:0]  req3;
  logic [11:0] data3;
  logic        ready3;
  logic        valid3;
  logic [3:0]  odata3;
  logic [2:0]  ack3;
  logic [2:0]  grant3;
  logic [1:0]  sel3;

  int checks;
  int errors;

  // reference model state per instance: 0 = N4, 1 = N3
  int m_busy [2];
  int m_sel  [2];
  int m_cnt  [2];
  int m_ptr  [2];

  // outputs captured at the most recent observation point
  logic       obs_valid4;
  logic [3:0] obs_data4;
  logic [3:0] obs_ack4;
  logic [3:0] obs_grant4;
  logic [1:0] obs_sel4;
  logic [3:0] obs_grant3;
  logic [1:0] obs_sel3;

  mux_rr_scheduler #(.N(4), .m(2), .W(4), .BURST(BURST)) u4 (
    .clk(clk), .rst(rst), .req(req4), .in_data(data4), .out_ready(ready4),
    .out_valid(valid4), .out_data(odata4), .ack(ack4), .grant(grant4), .select(sel4)
  );

  mux_rr_scheduler #(.N(3), .m(2), .W(4), .BURST(BURST)) u3 (
    .clk(clk), .rst(rst), .req(req3), .in_data(data3), .out_ready(ready3),
    .out_valid(valid3), .out_data(odata3), .ack(ack3), .grant(grant3), .select(sel3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected outputs follow directly from the model's notion of who owns the mux.
  task automatic check_inst(input int d, input logic v, input logic [3:0] od,
                            input logic [3:0] a, input logic [3:0] g, input logic [1:0] s,
                            input logic [3:0] rq, input logic [15:0] dt, input logic rd);
    logic       ev;
    logic [3:0] ed;
    logic [3:0] ea;
    logic [3:0] eg;
    ev = (m_busy[d] != 0) && rq[m_sel[d]];
    ed = ev ? dt[m_sel[d]*4 +: 4] : 4'h0;
    ea = (ev && rd) ? 4'(1 << m_sel[d]) : 4'h0;
    eg = (m_busy[d] != 0) ? 4'(1 << m_sel[d]) : 4'h0;
    chk($sformatf("u%0d out_valid", d), 32'(v),  32'(ev));
    chk($sformatf("u%0d out_data",  d), 32'(od), 32'(ed));
    chk($sformatf("u%0d ack",       d), 32'(a),  32'(ea));
    chk($sformatf("u%0d grant",     d), 32'(g),  32'(eg));
    chk($sformatf("u%0d select",    d), 32'(s),  32'(m_sel[d]));
  endtask

  task automatic model_edge(input int d, input logic r, input logic [3:0] rq, input logic rd);
    int n;
    n = (d == 0) ? 4 : 3;
    if (r) begin
      m_busy[d] = 0; m_ptr[d] = 0; m_sel[d] = 0; m_cnt[d] = 0;
    end else if (m_busy[d] == 0) begin
      if (rq != 4'h0) begin
        for (int k = n - 1; k >= 0; k--) begin
          if (rq[(m_ptr[d] + k) % n]) m_sel[d] = (m_ptr[d] + k) % n;
        end
        m_busy[d] = 1;
        m_cnt[d]  = 0;
      end
    end else if (!rq[m_sel[d]]) begin
      m_busy[d] = 0;
      m_ptr[d]  = (m_sel[d] + 1) % n;
    end else if (rd) begin
      if (m_cnt[d] == BURST - 1) begin
        m_busy[d] = 0;
        m_ptr[d]  = (m_sel[d] + 1) % n;
      end else begin
        m_cnt[d] = m_cnt[d] + 1;
      end
    end
  endtask

  // One clock cycle: drive on negedge, check against the model, then advance the model.
  task automatic step(input logic r, input logic [3:0] rq, input logic [15:0] dt, input logic rd,
                      input logic [2:0] rq3, input logic [11:0] dt3, input logic rd3);
    @(negedge clk);
    rst = r; req4 = rq; data4 = dt; ready4 = rd;
    req3 = rq3; data3 = dt3; ready3 = rd3;
    #1;
    obs_valid4 = valid4; obs_data4 = odata4; obs_ack4 = ack4;
    obs_grant4 = grant4; obs_sel4 = sel4;
    obs_grant3 = grant3; obs_sel3 = sel3;
    check_inst(0, valid4, odata4, ack4, grant4, sel4, rq, dt, rd);
    check_inst(1, valid3, odata3, {1'b0, ack3}, {1'b0, grant3}, sel3,
               {1'b0, rq3}, {4'h0, dt3}, rd3);
    @(posedge clk);
    model_edge(0, r, rq, rd);
    model_edge(1, r, {1'b0, rq3}, rd3);
  endtask

  initial begin
    logic [3:0] exp_ack_single [5];
    logic [3:0] exp_rr4 [15];
    logic [2:0] exp_rr3 [15];
    logic [1:0] exp_sel3 [15];

    exp_ack_single = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h1};
    exp_rr4  = '{0, 1, 1, 0, 2, 2, 0, 4, 4, 0, 8, 8, 0, 1, 1};
    exp_rr3  = '{0, 1, 1, 0, 2, 2, 0, 4, 4, 0, 1, 1, 0, 2, 2};
    exp_sel3 = '{0, 0, 0, 0, 1, 1, 1, 2, 2, 2, 0, 0, 0, 1, 1};

    checks = 0;
    errors = 0;
    for (int d = 0; d < 2; d++) begin
      m_busy[d] = 0; m_sel[d] = 0; m_cnt[d] = 0; m_ptr[d] = 0;
    end
    rst = 1'b1; req4 = '0; data4 = '0; ready4 = 1'b0;
    req3 = '0; data3 = '0; ready3 = 1'b0;
    repeat (2) @(posedge clk);

    // Single requester: 2 beats, one idle cycle, re-grant of requester 0
    for (int i = 0; i < 5; i++) begin
      step(0, 4'b0001, 16'h000A, 1, 3'b000, 12'h0, 0);
      if (i == 0) begin
        chk("reset grant", 32'(obs_grant4), 32'h0);
        chk("reset select", 32'(obs_sel4), 32'h0);
        chk("reset valid", 32'(obs_valid4), 32'h0);
      end
      chk($sformatf("single ack[%0d]", i), 32'(obs_ack4), 32'(exp_ack_single[i]));
      if (exp_ack_single[i] != 0) chk($sformatf("single data[%0d]", i), 32'(obs_data4), 32'hA);
    end

    // Round robin on both instances, all requesters active
    step(1, 4'b0000, 16'h0, 1, 3'b000, 12'h0, 1);
    for (int i = 0; i < 15; i++) begin
      step(0, 4'b1111, 16'h4321, 1, 3'b111, 12'h765, 1);
      chk($sformatf("rr4 grant[%0d]", i), 32'(obs_grant4), 32'(exp_rr4[i]));
      chk($sformatf("rr3 grant[%0d]", i), 32'(obs_grant3), 32'(exp_rr3[i]));
      chk($sformatf("rr3 select[%0d]", i), 32'(obs_sel3), 32'(exp_sel3[i]));
    end

    // Backpressure on requester 2
    step(1, 4'b0000, 16'h0, 0, 3'b000, 12'h0, 0);
    step(0, 4'b0100, 16'h0C00, 0, 3'b000, 12'h0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 4'b0100, 16'h0C00, 0, 3'b000, 12'h0, 0);
      chk($sformatf("bp hold grant[%0d]", i), 32'(obs_grant4), 32'h4);
      chk($sformatf("bp hold ack[%0d]", i), 32'(obs_ack4), 32'h0);
      chk($sformatf("bp hold valid[%0d]", i), 32'(obs_valid4), 32'h1);
    end
    for (int i = 0; i < 2; i++) begin
      step(0, 4'b0100, 16'h0C00, 1, 3'b000, 12'h0, 0);
      chk($sformatf("bp ack[%0d]", i), 32'(obs_ack4), 32'h4);
    end
    step(0, 4'b0100, 16'h0C00, 1, 3'b000, 12'h0, 0);
    chk("bp release grant", 32'(obs_grant4), 32'h0);

    // Early drop by requester 1 after one beat, then ptr=2
    step(1, 4'b0000, 16'h0, 1, 3'b000, 12'h0, 0);
    step(0, 4'b0010, 16'h0050, 1, 3'b000, 12'h0, 0);
    step(0, 4'b0010, 16'h0050, 1, 3'b000, 12'h0, 0);
    chk("drop first ack", 32'(obs_ack4), 32'h2);
    step(0, 4'b0000, 16'h0050, 1, 3'b000, 12'h0, 0);
    chk("drop no ack", 32'(obs_ack4), 32'h0);
    step(0, 4'b1111, 16'h0050, 1, 3'b000, 12'h0, 0);
    chk("drop idle grant", 32'(obs_grant4), 32'h0);
    step(0, 4'b1111, 16'h0050, 1, 3'b000, 12'h0, 0);
    chk("drop next grant", 32'(obs_grant4), 32'h4);

    // Reset mid-burst of requester 3
    step(1, 4'b0000, 16'h0, 1, 3'b000, 12'h0, 0);
    step(0, 4'b1000, 16'hE000, 1, 3'b000, 12'h0, 0);
    step(1, 4'b1000, 16'hE000, 1, 3'b000, 12'h0, 0);
    chk("rstmid beat0 grant", 32'(obs_grant4), 32'h8);
    step(0, 4'b1010, 16'hE000, 1, 3'b000, 12'h0, 0);
    chk("rstmid grant", 32'(obs_grant4), 32'h0);
    chk("rstmid select", 32'(obs_sel4), 32'h0);
    chk("rstmid valid", 32'(obs_valid4), 32'h0);
    step(0, 4'b1010, 16'hE000, 1, 3'b000, 12'h0, 0);
    chk("rstmid next grant", 32'(obs_grant4), 32'h2);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) == 0),
           4'($urandom), 16'($urandom), ($urandom_range(0, 3) != 0),
           3'($urandom), 12'($urandom), ($urandom_range(0, 3) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_rr_scheduler.md
MUX_RR_SCHEDULER -- requirements
Module: mux_rr_scheduler

Interface
REQ-001 Parameter N, default 4: number of requesters sharing the mux, N >= 2.
REQ-002 Parameter m, default 2: select width, equal to ceil(log2(N)).
REQ-003 Parameter W, default 4: data width per requester.
REQ-004 Parameter BURST, default 2: maximum beats per grant, BURST >= 1.
REQ-005 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-006 Port rst, input, 1: synchronous, active-high reset.
REQ-007 Port req, input, N: req[i] high means requester i has a beat to send.
REQ-008 Port in_data, input, N*W: requester i data on bits [i*W+W-1 : i*W].
REQ-009 Port out_ready, input, 1: downstream accepts the current beat.
REQ-010 Port out_valid, output, 1: a beat is presented on out_data.
REQ-011 Port out_data, output, W: data of the granted requester.
REQ-012 Port ack, output, N: one-hot pulse to the requester whose beat transferred this cycle.
REQ-013 Port grant, output, N: one-hot registered owner of the mux; all zero when idle.
REQ-014 Port select, output, m: registered mux select, equal to the index of the granted requester.

Function
REQ-015 The block SHALL implement a two-state FSM: IDLE and GRANT.
REQ-016 In IDLE with req != 0, the block SHALL pick the first requester with req high, searching from ptr upward modulo N, then load select, grant, and beat count 0, and enter GRANT on the next edge.
REQ-017 In IDLE with req == 0, the state and ptr SHALL not change.
REQ-018 Latency SHALL be one cycle: req sampled high at edge t gives out_valid high in the cycle after edge t.
REQ-019 In GRANT, out_valid SHALL equal req[select], combinationally.
REQ-020 In GRANT, out_data SHALL equal in_data for the selected requester. Outside a valid cycle, out_data SHALL be 0.
REQ-021 A transfer occurs when out_valid and out_ready are both high; ack[select] SHALL be high in that cycle only; ack SHALL be 0 otherwise.
REQ-022 On a transfer with beat count == BURST-1, the block SHALL return to IDLE.
REQ-023 On a transfer with beat count < BURST-1, the block SHALL stay in GRANT and increment the count.
REQ-024 In GRANT with req[select] low, the block SHALL return to IDLE without a transfer, even mid-burst.
REQ-025 On every GRANT->IDLE transition, ptr SHALL become select+1, wrapping from N-1 to 0. This applies for non-power-of-two N; select SHALL never exceed N-1.
REQ-026 In IDLE, grant SHALL be 0, out_valid 0, and ack 0. The select output SHALL hold its last value.
REQ-027 There SHALL be exactly one idle cycle between consecutive grants.
REQ-028 With out_ready held low, the grant SHALL be held indefinitely while req[select] stays high; there is no timeout.
REQ-029 Changes in req of non-granted requesters during GRANT SHALL have no effect until the next IDLE arbitration.
REQ-030 The beat count SHALL be ceil(log2(BURST+1)) bits wide and SHALL never exceed BURST-1.

Reset
REQ-031 When rst is high at an edge, the block SHALL set: state IDLE, ptr 0, select 0, grant 0, beat count 0. Consequently out_valid, ack and out_data are 0 in the next cycle.
REQ-032 Reset SHALL take priority over all other events, including an in-flight transfer. An aborted burst SHALL not be resumed.

Verification (N=4, W=4, BURST=2)
REQ-033 Single requester: req=0001, in_data[3:0]=0xA, out_ready=1.
- out_valid is high the cycle after req.
- out_data=0xA, ack=0001 for 2 beats.
- Then 1 idle cycle, then re-grant of requester 0 (ptr=1 finds 0 after wrap).
REQ-034 Round robin: req=1111 held, out_ready=1 → grant sequence 0001, 0010, 0100, 1000, 0001. Each grant lasts 2 beats, separated by 1 idle cycle.
REQ-035 Backpressure: requester 2 granted, out_ready=0 for 5 cycles.
- out_valid stays high, ack=0, grant=0100 held.
- On out_ready=1, the 2 beats complete.
REQ-036 Early drop: requester 1 deasserts req after 1 beat → GRANT→IDLE with no second ack, then ptr=2.
REQ-037 Reset mid-burst: rst pulsed during requester 3 beat 0 with out_ready=1.
- Next cycle: grant=0, select=0, out_valid=0.
- With req=1010, the next grant is requester 1.
REQ-038 N=3 (m=2) wrap: req=111 cycles select 0,1,2,0. select=3 never appears.
